// File: rtl/frq_pkg.sv
// Shared definitions for the frequency meter: FSM states, code width and
// default code-window geometry matched to the loadable divider settings.
package frq_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEAS = 1'b1
    } state_t;

    localparam int unsigned CODE_W    = 3;
    localparam int unsigned CODE_MAX  = (1 << CODE_W) - 1;

    localparam int unsigned PMIN_DEF  = 8;
    localparam int unsigned PSTEP_DEF = 4;
    localparam int unsigned TOL_DEF   = 1;

endpackage

// File: rtl/frq_meter_edge_sync.sv
// Two-flop synchronizer for an asynchronous pulse train, followed by a third
// flop used to produce a one-cycle rising-edge strobe.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic e
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain plus the delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign e = s2 & ~s3;

endmodule

// File: rtl/frq_meter.sv
// Period meter for divided pulse trains: counts clk cycles between rising
// edges of sig_in, decodes the period back to a 3-bit divider code and flags
// lock when two consecutive measurements agree.
module frq_meter
    import frq_pkg::*;
#(
    parameter int unsigned CW         = 10,
    parameter int unsigned MAX_PERIOD = 1023,
    parameter int unsigned PMIN       = PMIN_DEF,
    parameter int unsigned PSTEP      = PSTEP_DEF,
    parameter int unsigned TOL        = TOL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              sig_in,
    output logic [CW-1:0]     period,
    output logic              meas_valid,
    output logic [CODE_W-1:0] code,
    output logic              code_ok,
    output logic              locked,
    output logic [CODE_W-1:0] lock_code,
    output logic              timeout
);

    localparam logic [CW:0] PMIN_X     = (CW+1)'(PMIN);
    localparam logic [CW:0] PSTEP_X    = (CW+1)'(PSTEP);
    localparam logic [CW:0] TOL_X      = (CW+1)'(TOL);
    localparam logic [CW:0] CODE_MAX_X = (CW+1)'(CODE_MAX);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PERIOD);

    logic clr;
    logic e;

    state_t      state;
    state_t      state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic        meas_n;
    logic        tmo_n;

    logic [CW:0]         cnt_x;
    logic [CW:0]         dec_k;
    logic [CW:0]         dec_nom;
    logic                dec_ok;
    logic [CODE_W-1:0]   dec_code;

    logic                hist_ok;
    logic [CODE_W-1:0]   hist_code;

    // init clears everything that rst clears in this block
    assign clr = rst | init;

    edge_sync u_edge_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_in),
        .e   (e)
    );

    // FSM state and period counter registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic: start on first edge, measure on later edges, time out
    // when the counter reaches MAX_PERIOD without an edge (edge takes priority)
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        meas_n  = 1'b0;
        tmo_n   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (e) begin
                    state_n = S_MEAS;
                    cnt_n   = CW'(1);
                end
            end
            S_MEAS: begin
                if (e) begin
                    meas_n = 1'b1;
                    cnt_n  = CW'(1);
                end else if (cnt == MAX_CNT) begin
                    tmo_n   = 1'b1;
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Decode of the running count; the TOL offset rounds a period into the
    // window of the nearest code, then the window bound is checked explicitly
    always_comb begin
        cnt_x    = {1'b0, cnt};
        dec_k    = (cnt_x + TOL_X - PMIN_X) / PSTEP_X;
        dec_nom  = PMIN_X + dec_k * PSTEP_X;
        dec_ok   = (cnt_x >= PMIN_X - TOL_X) &&
                   (dec_k <= CODE_MAX_X) &&
                   (cnt_x <= dec_nom + TOL_X);
        dec_code = dec_k[CODE_W-1:0];
    end

    // Measurement results, strobes and lock tracking
    always_ff @(posedge clk) begin
        if (clr) begin
            period     <= '0;
            meas_valid <= 1'b0;
            code       <= '0;
            code_ok    <= 1'b0;
            locked     <= 1'b0;
            lock_code  <= '0;
            timeout    <= 1'b0;
            hist_ok    <= 1'b0;
            hist_code  <= '0;
        end else begin
            meas_valid <= meas_n;
            timeout    <= tmo_n;
            if (meas_n) begin
                period  <= cnt;
                code_ok <= dec_ok;
                if (dec_ok) begin
                    code <= dec_code;
                end
                if (dec_ok && hist_ok && (dec_code == hist_code)) begin
                    locked    <= 1'b1;
                    lock_code <= dec_code;
                end else begin
                    locked <= 1'b0;
                end
                hist_ok   <= dec_ok;
                hist_code <= dec_code;
            end else if (tmo_n) begin
                locked    <= 1'b0;
                hist_ok   <= 1'b0;
                hist_code <= '0;
            end
        end
    end

endmodule

// File: tb/tb_frq_meter.sv
// Scoreboard bench for frq_meter: the stimulus side models the expected
// measurement for every edge it drives; the monitor pops and compares.
`timescale 1ns/1ps
module tb_frq_meter;

    localparam int CW    = 10;
    localparam int MAXP  = 1023;
    localparam int PMIN  = 8;
    localparam int PSTEP = 4;
    localparam int TOL   = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic          sig_in;
    logic [CW-1:0] period;
    logic          meas_valid;
    logic [2:0]    code;
    logic          code_ok;
    logic          locked;
    logic [2:0]    lock_code;
    logic          timeout;

    always #5 clk = ~clk;

    frq_meter #(
        .CW         (CW),
        .MAX_PERIOD (MAXP),
        .PMIN       (PMIN),
        .PSTEP      (PSTEP),
        .TOL        (TOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .sig_in     (sig_in),
        .period     (period),
        .meas_valid (meas_valid),
        .code       (code),
        .code_ok    (code_ok),
        .locked     (locked),
        .lock_code  (lock_code),
        .timeout    (timeout)
    );

    typedef struct {
        bit is_tmo;
        int per;
        int cd;
        bit ok;
        bit lk;
        int lc;
    } exp_t;

    exp_t   sb[$];
    exp_t   got_x;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_mv     = 0;
    longint cyc      = 0;
    longint last_mv_cyc = 0;

    // reference model state
    bit m_active = 0;
    bit m_hok    = 0;
    bit m_lock   = 0;
    int m_hcode  = 0;
    int m_code   = 0;
    int m_lcode  = 0;
    int m_period = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // window search over every code, independent of any division
    task automatic m_decode(input int p, output bit ok, output int k);
        ok = 0;
        k  = 0;
        for (int i = 0; i < 8; i++) begin
            if (p >= PMIN + i*PSTEP - TOL && p <= PMIN + i*PSTEP + TOL) begin
                ok = 1;
                k  = i;
            end
        end
    endtask

    task automatic m_measure(input int p);
        bit   ok;
        int   k;
        exp_t t;
        m_decode(p, ok, k);
        m_period = p;
        if (ok) m_code = k;
        if (ok && m_hok && k == m_hcode) begin
            m_lock  = 1;
            m_lcode = k;
        end else begin
            m_lock = 0;
        end
        m_hok   = ok;
        m_hcode = k;
        t.is_tmo = 0; t.per = p; t.cd = m_code; t.ok = ok; t.lk = m_lock; t.lc = m_lcode;
        sb.push_back(t);
    endtask

    task automatic m_timeout();
        exp_t t;
        m_lock   = 0;
        m_hok    = 0;
        m_active = 0;
        t.is_tmo = 1; t.per = m_period; t.cd = m_code; t.ok = 0; t.lk = 0; t.lc = m_lcode;
        sb.push_back(t);
    endtask

    task automatic m_reset();
        m_active = 0; m_hok = 0; m_lock = 0;
        m_hcode = 0; m_code = 0; m_lcode = 0; m_period = 0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_period"},     period,     0);
        check_eq({pfx, "_meas_valid"}, meas_valid, 0);
        check_eq({pfx, "_code"},       code,       0);
        check_eq({pfx, "_code_ok"},    code_ok,    0);
        check_eq({pfx, "_locked"},     locked,     0);
        check_eq({pfx, "_lock_code"},  lock_code,  0);
        check_eq({pfx, "_timeout"},    timeout,    0);
    endtask

    // first edge of a train: starts a measurement, produces no result
    task automatic first_edge();
        @(posedge clk); #1 sig_in = 1'b1;
        m_active = 1;
    endtask

    // called right after a rise: next rise comes p cycles later
    task automatic run_period(input int p);
        repeat (2) @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (p - 2) @(posedge clk);
        #1 sig_in = 1'b1;
        m_measure(p);
    endtask

    task automatic stop_and_timeout();
        repeat (2) @(posedge clk);
        #1 sig_in = 1'b0;
        m_timeout();
        repeat (MAXP + 20) @(posedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every strobe must match the oldest expectation
    always @(negedge clk) begin
        if (meas_valid || timeout) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_mv",  meas_valid, 0);
                check_eq("unexpected_tmo", timeout,    0);
            end else begin
                got_x = sb.pop_front();
                check_eq("evt_timeout",  timeout,    got_x.is_tmo);
                check_eq("evt_mv",       meas_valid, !got_x.is_tmo);
                check_eq("evt_period",   period,     got_x.per);
                check_eq("evt_code",     code,       got_x.cd);
                check_eq("evt_locked",   locked,     got_x.lk);
                check_eq("evt_lock_code", lock_code, got_x.lc);
                if (got_x.is_tmo)
                    check_eq("tmo_delay", cyc - last_mv_cyc, MAXP);
                else
                    check_eq("evt_code_ok", code_ok, got_x.ok);
            end
            if (meas_valid) begin
                n_mv++;
                last_mv_cyc = cyc;
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        init   = 1'b0;
        sig_in = 1'b0;
        // reset with the input toggling
        @(posedge clk); #1 sig_in = 1'b1;
        @(posedge clk); #1 sig_in = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst");
        repeat (5) @(posedge clk);

        // first edge after reset: no measurement
        first_edge();
        repeat (6) @(posedge clk);
        check_eq("rst_first_edge_no_mv", n_mv, 0);
        #1 sig_in = 1'b0;
        repeat (14) @(posedge clk);
        #1 sig_in = 1'b1;
        m_measure(20);               // code 3, not yet locked
        run_period(20);              // lock on 3

        // tolerance
        run_period(21);              // still code 3, locked
        run_period(22);              // outside window, unlock

        // relock, then code change
        run_period(20);
        run_period(20);
        run_period(28);              // code 5, unlock
        run_period(28);              // lock on 5

        // timeout
        stop_and_timeout();

        // after timeout: first edge silent, then edge exactly at MAX_PERIOD
        first_edge();
        run_period(MAXP);
        run_period(20);
        run_period(20);

        // init with counter at 12
        repeat (2) @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (12) @(posedge clk);
        #1 init = 1'b1;
        @(posedge clk); #1 init = 1'b0;
        @(negedge clk);
        check_all_zero("init");
        m_reset();

        // relock needs three fresh edges
        first_edge();
        run_period(20);
        run_period(20);
        repeat (10) @(posedge clk);

        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
